// File: rtl/pressed_event_pkg.sv
// Shared constants and helpers for the push-button front end.
package pressed_event_pkg;

    localparam int N_CH_DEF        = 4;
    localparam int ACT_LOW_DEF     = 0;
    localparam int DEB_CYCLES_DEF  = 4;
    localparam int HOLD_CYCLES_DEF = 16;
    localparam int RST_CH_DEF      = 0;
    localparam int RST_PULSE_DEF   = 8;

    localparam logic RG_IDLE   = 1'b0;
    localparam logic RG_ACTIVE = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pressed_event_gen_key_chan.sv
// One key channel: synchroniser, polarity fix, debounce,
// hold timer and press/release/long strobes.
module key_chan
    import pressed_event_pkg::*;
#(
    parameter int ACT_LOW     = ACT_LOW_DEF,
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic clk_out,
    input  logic reset_n,
    input  logic in_trig,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int CW = clog2(DEB_CYCLES + 1);
    localparam int HW = clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic POL = (ACT_LOW != 0);

    logic sync1_q, sync2_q;
    logic level_q, level_d;
    logic press_q, press_d;
    logic release_q, release_d;
    logic long_q, long_d;
    logic fired_q, fired_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic s;
    logic toggle;

    assign s      = sync2_q ^ POL;
    assign toggle = (s != level_q) && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d     = cnt_q;
        level_d   = level_q;
        hcnt_d    = hcnt_q;
        fired_d   = fired_q;
        long_d    = 1'b0;
        press_d   = toggle & ~level_q;
        release_d = toggle & level_q;

        if (s == level_q) begin
            cnt_d = '0;
        end else if (toggle) begin
            cnt_d   = '0;
            level_d = ~level_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // a release on this edge wins over a would-be long strobe
        if (press_d) begin
            hcnt_d = '0;
        end else if (release_d) begin
            hcnt_d  = '0;
            fired_d = 1'b0;
        end else if (level_q && !fired_q) begin
            hcnt_d = hcnt_q + 1'b1;
            if (hcnt_q == HOLD_LAST) begin
                long_d  = 1'b1;
                fired_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_out or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            fired_q   <= 1'b0;
            cnt_q     <= '0;
            hcnt_q    <= '0;
        end else begin
            sync1_q   <= in_trig;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            fired_q   <= fired_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;

endmodule

// File: rtl/pressed_event_gen.sv
// Multi-channel push-button front end with a stretched
// system reset driven by block reset or a long press.
module pressed_event_gen
    import pressed_event_pkg::*;
#(
    parameter int N_CH        = N_CH_DEF,
    parameter int ACT_LOW     = ACT_LOW_DEF,
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int RST_CH      = RST_CH_DEF,
    parameter int RST_PULSE   = RST_PULSE_DEF
) (
    input  logic            clk_out,
    input  logic            reset_n,
    input  logic [N_CH-1:0] in_trig,
    output logic [N_CH-1:0] key_level,
    output logic [N_CH-1:0] key_press,
    output logic [N_CH-1:0] key_release,
    output logic [N_CH-1:0] key_long,
    output logic            sys_rst_n
);

    localparam int RW = clog2(RST_PULSE + 1);
    localparam logic [RW-1:0] PULSE = RW'(RST_PULSE);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        key_chan #(
            .ACT_LOW    (ACT_LOW),
            .DEB_CYCLES (DEB_CYCLES),
            .HOLD_CYCLES(HOLD_CYCLES)
        ) u_chan (
            .clk_out    (clk_out),
            .reset_n    (reset_n),
            .in_trig    (in_trig[g]),
            .key_level  (key_level[g]),
            .key_press  (key_press[g]),
            .key_release(key_release[g]),
            .key_long   (key_long[g])
        );
    end

    logic          state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          srst_q, srst_d;

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        srst_d  = srst_q;
        case (state_q)
            RG_IDLE: begin
                if (key_long[RST_CH]) begin
                    state_d = RG_ACTIVE;
                    rcnt_d  = PULSE;
                    srst_d  = 1'b0;
                end
            end
            RG_ACTIVE: begin
                // a long press while active stretches the pulse
                if (key_long[RST_CH]) begin
                    rcnt_d = PULSE;
                end else begin
                    rcnt_d = rcnt_q - 1'b1;
                    if (rcnt_q == RW'(1)) begin
                        srst_d  = 1'b1;
                        state_d = RG_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_out or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RG_ACTIVE;
            rcnt_q  <= PULSE;
            srst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            srst_q  <= srst_d;
        end
    end

    assign sys_rst_n = srst_q;

endmodule

// File: tb/tb_pressed_event_gen.sv
// Directed bench for pressed_event_gen: default instance
// plus an active-low instance.
module tb_pressed_event_gen;

    logic       clk = 1'b0;
    logic       rst_n, rst_al_n;
    logic [3:0] trig, trig_al;
    logic [3:0] lvl, prs, rel, lng;
    logic [3:0] lvl_al, prs_al, rel_al, lng_al;
    logic       srst, srst_al;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pressed_event_gen u_dut (
        .clk_out    (clk),
        .reset_n    (rst_n),
        .in_trig    (trig),
        .key_level  (lvl),
        .key_press  (prs),
        .key_release(rel),
        .key_long   (lng),
        .sys_rst_n  (srst)
    );

    pressed_event_gen #(.ACT_LOW(1)) u_al (
        .clk_out    (clk),
        .reset_n    (rst_al_n),
        .in_trig    (trig_al),
        .key_level  (lvl_al),
        .key_press  (prs_al),
        .key_release(rel_al),
        .key_long   (lng_al),
        .sys_rst_n  (srst_al)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        rst_al_n = 1'b0;
        trig     = 4'h0;
        trig_al  = 4'hF;
        repeat (3) tick();
        chk("rst_srst", 32'(srst), 32'd0);
        chk("rst_outs", 32'({lvl, prs, rel, lng}), 32'd0);

        // reset release: sys_rst_n rises on the 8th edge
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk("por_srst", 32'(srst), 32'(e >= 8));
            chk("por_outs", 32'({lvl, prs, rel, lng}), 32'd0);
        end

        // clean press and release on ch1
        trig[1] = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk("p1_lvl", 32'(lvl[1]), 32'(e >= 6));
            chk("p1_prs", 32'(prs), (e == 6) ? 32'h2 : 32'h0);
        end
        tick();
        chk("p1_prs_off", 32'(prs), 32'd0);
        trig[1] = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk("r1_lvl", 32'(lvl[1]), 32'(e < 6));
            chk("r1_rel", 32'(rel), (e == 6) ? 32'h2 : 32'h0);
        end

        // glitches of 3 and 2 cycles on ch2
        for (int g = 3; g >= 2; g--) begin
            trig[2] = 1'b1;
            repeat (g) begin
                tick();
                chk("gl_hi", 32'({lvl[2], prs[2], rel[2]}), 32'd0);
            end
            trig[2] = 1'b0;
            repeat (8) begin
                tick();
                chk("gl_lo", 32'({lvl[2], prs[2], rel[2]}), 32'd0);
            end
        end

        // long hold on ch3: one key_long, 16 after key_press
        trig[3] = 1'b1;
        for (int e = 1; e <= 36; e++) begin
            tick();
            chk("h3_prs", 32'(prs[3]), 32'(e == 6));
            chk("h3_lng", 32'(lng), (e == 22) ? 32'h8 : 32'h0);
        end
        trig[3] = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk("h3_lng_rel", 32'(lng), 32'd0);
            chk("h3_rel", 32'(rel), (e == 6) ? 32'h8 : 32'h0);
        end

        // long press on ch0 with ch1-3 pressed together
        trig = 4'hF;
        for (int e = 1; e <= 34; e++) begin
            tick();
            chk("lp_prs", 32'(prs), (e == 6) ? 32'hF : 32'h0);
            chk("lp_lng", 32'(lng), (e == 22) ? 32'hF : 32'h0);
            chk("lp_srst", 32'(srst), 32'(!(e >= 23 && e <= 30)));
        end
        trig = 4'h0;
        repeat (7) tick();
        chk("lp_idle", 32'({lvl, srst}), 32'd1);

        // active-low instance
        chk("al_rst_srst", 32'(srst_al), 32'd0);
        rst_al_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            chk("al_idle", 32'({lvl_al, prs_al, rel_al}), 32'd0);
        end
        trig_al[0] = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk("al_prs", 32'(prs_al), (e == 6) ? 32'h1 : 32'h0);
            chk("al_lvl", 32'(lvl_al), (e >= 6) ? 32'h1 : 32'h0);
        end
        trig_al[0] = 1'b1;
        repeat (4) tick();
        chk("al_mid", 32'({lvl_al, rel_al}), 32'h10);
        rst_al_n = 1'b0;
        #1;
        chk("al_async", 32'({lvl_al, prs_al, rel_al, lng_al}), 32'd0);
        repeat (2) tick();
        rst_al_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            chk("al_post", 32'({lvl_al, prs_al, rel_al, lng_al}), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
